// File: rtl/note_gate_sequencer.sv
// note_gate_sequencer: buffers {gap, duration} note events and plays them back
// on the envelope cmd line (0 = PRESS, 1 = RELEASE) with tick-exact timing.
module note_gate_sequencer #(
  parameter int BOARD_CLOCKSPEED = 50000000,
  parameter int TICK_HZ          = 1000,
  parameter int FIFO_DEPTH       = 4,
  parameter int DUR_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic [DUR_W-1:0]            ev_duration,
  input  logic [DUR_W-1:0]            ev_gap,
  input  logic                        flush,
  output logic                        cmd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int P  = BOARD_CLOCKSPEED / TICK_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [PW-1:0]    P_LAST  = PW'(P - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [DUR_W-1:0] ONE     = DUR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e              state_q;
  logic                cmd_q;
  logic [DUR_W-1:0]    dur_q;
  logic [DUR_W-1:0]    gap_q;
  logic [PW-1:0]       presc_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic [2*DUR_W-1:0]  mem_q [FIFO_DEPTH];

  logic                tick;
  logic                push;
  logic                pop;
  logic [DUR_W-1:0]    head_dur;
  logic [DUR_W-1:0]    head_gap;

  // Readiness uses only the registered count, so a same-cycle pop never frees a full FIFO.
  assign ev_ready = (count_q < DEPTH_C) && !flush;
  assign push     = ev_valid && ev_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !flush;
  assign tick     = (presc_q == P_LAST);

  assign {head_gap, head_dur} = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ev_gap, ev_duration};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Restarting the prescaler on each pop aligns every note to a full tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (flush || pop || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= 1'b1;
      dur_q   <= '0;
      gap_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cmd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_PRESS;
            cmd_q   <= 1'b0;
            dur_q   <= (head_dur == '0) ? ONE : head_dur;
            gap_q   <= head_gap;
          end
        end
        S_PRESS: begin
          if (tick) begin
            if (dur_q == ONE) begin
              state_q <= S_GAP;
              cmd_q   <= 1'b1;
            end else begin
              dur_q <= dur_q - ONE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            if (gap_q == ONE) begin
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q - ONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cmd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign cmd        = cmd_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_note_gate_sequencer.sv
// Directed bench for note_gate_sequencer with P = 10 clk cycles per tick and a 4-deep FIFO.
module tb_note_gate_sequencer;
  logic        clk         = 1'b0;
  logic        rst_n       = 1'b1;
  logic        ev_valid    = 1'b0;
  logic        ev_ready;
  logic [15:0] ev_duration = '0;
  logic [15:0] ev_gap      = '0;
  logic        flush       = 1'b0;
  logic        cmd;
  logic        busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  int n;
  int wait_n;
  int stall5;
  int stall_n;
  logic [2:0] cnt_full;
  logic       rdy_full;
  logic       rdy;

  int d4[6]       = '{1, 2, 1, 3, 1, 2};
  int g4[6]       = '{1, 0, 0, 0, 0, 0};
  int exp_run[11] = '{10, 11, 20, 2, 10, 2, 30, 2, 10, 2, 20};

  note_gate_sequencer #(
    .BOARD_CLOCKSPEED(1000),
    .TICK_HZ         (100),
    .FIFO_DEPTH      (4),
    .DUR_W           (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_duration(ev_duration),
    .ev_gap     (ev_gap),
    .flush      (flush),
    .cmd        (cmd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Length in cycles of the current run of cmd (sel=0) or busy (sel=1) at level lvl.
  task automatic run_len(input int sel, input logic lvl, output int len);
    len = 0;
    while ((((sel == 0) ? cmd : busy) === lvl) && (len < 400)) begin
      len++;
      step();
    end
  endtask

  task automatic wait_cmd_low(output int cyc);
    cyc = 0;
    while ((cmd !== 1'b0) && (cyc < 100)) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cmd", 32'(cmd), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(ev_ready), 32'd1);

    // Test 1: D=3, G=2
    ev_valid = 1'b1; ev_duration = 16'd3; ev_gap = 16'd2;
    step();
    ev_valid = 1'b0;
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_cmd_at_push", 32'(cmd), 32'd1);
    step();
    chk("t1_cmd_falls", 32'(cmd), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    run_len(0, 1'b0, n);
    chk("t1_press_len", 32'(n), 32'd30);
    run_len(1, 1'b1, n);
    chk("t1_gap_busy_len", 32'(n), 32'd20);
    chk("t1_cmd_idle", 32'(cmd), 32'd1);

    // Test 2: D=1,G=0 then D=2,G=1 back-to-back
    ev_valid = 1'b1; ev_duration = 16'd1; ev_gap = 16'd0;
    step();
    ev_duration = 16'd2; ev_gap = 16'd1;
    step();
    ev_valid = 1'b0;
    chk("t2_count", 32'(fifo_count), 32'd1);
    chk("t2_cmd_low", 32'(cmd), 32'd0);
    run_len(0, 1'b0, n);
    chk("t2_low1", 32'(n), 32'd10);
    run_len(0, 1'b1, n);
    chk("t2_high1", 32'(n), 32'd2);
    run_len(0, 1'b0, n);
    chk("t2_low2", 32'(n), 32'd20);
    run_len(1, 1'b1, n);
    chk("t2_gap_busy_len", 32'(n), 32'd10);
    chk("t2_count_end", 32'(fifo_count), 32'd0);

    // Test 3: zero duration plays as one tick
    ev_valid = 1'b1; ev_duration = 16'd0; ev_gap = 16'd0;
    step();
    ev_valid = 1'b0;
    step();
    chk("t3_cmd_low", 32'(cmd), 32'd0);
    run_len(0, 1'b0, n);
    chk("t3_low", 32'(n), 32'd10);
    run_len(1, 1'b1, n);
    chk("t3_gap_busy_len", 32'(n), 32'd1);

    // Test 4: six events offered continuously, FIFO fills and drains in order
    stall5 = 0; cnt_full = '0; rdy_full = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ev_valid    = 1'b1;
          ev_duration = 16'(d4[i]);
          ev_gap      = 16'(g4[i]);
          stall_n     = 0;
          rdy         = ev_ready;
          while (!rdy && stall_n < 100) begin
            stall_n++;
            step();
            rdy = ev_ready;
          end
          if (i == 5) stall5 = stall_n;
          step();
          $display("push event %0d D=%0d G=%0d stall=%0d", i, d4[i], g4[i], stall_n);
          if (i == 4) begin
            cnt_full = fifo_count;
            rdy_full = ev_ready;
          end
        end
        ev_valid = 1'b0;
      end
      begin
        wait_cmd_low(wait_n);
        chk("t4_start_latency", 32'(wait_n), 32'd2);
        for (int k = 0; k < 11; k++) begin
          run_len(0, ((k % 2) == 1) ? 1'b1 : 1'b0, n);
          chk($sformatf("t4_run%0d", k), 32'(n), 32'(exp_run[k]));
        end
        run_len(1, 1'b1, n);
        chk("t4_final_busy_len", 32'(n), 32'd1);
      end
    join
    chk("t4_full_count", 32'(cnt_full), 32'd4);
    chk("t4_full_ready", 32'(rdy_full), 32'd0);
    chk("t4_stall_cycles", 32'(stall5), 32'd18);
    chk("t4_count_end", 32'(fifo_count), 32'd0);

    // Test 5: flush mid-PRESS with 3 queued and ev_valid held high
    ev_valid = 1'b1; ev_duration = 16'd5; ev_gap = 16'd0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_count_before", 32'(fifo_count), 32'd3);
    chk("t5_cmd_before", 32'(cmd), 32'd0);
    flush = 1'b1;
    #1;
    chk("t5_ready_in_flush", 32'(ev_ready), 32'd0);
    step();
    flush = 1'b0;
    ev_valid = 1'b0;
    chk("t5_cmd", 32'(cmd), 32'd1);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    step();
    chk("t5_cmd_stays", 32'(cmd), 32'd1);

    // Test 6: async reset mid-PRESS, then a fresh note
    ev_valid = 1'b1; ev_duration = 16'd4; ev_gap = 16'd0;
    step();
    step();
    ev_valid = 1'b0;
    step();
    step();
    chk("t6_cmd_before", 32'(cmd), 32'd0);
    chk("t6_count_before", 32'(fifo_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cmd_async", 32'(cmd), 32'd1);
    chk("t6_count_async", 32'(fifo_count), 32'd0);
    chk("t6_busy_async", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("t6_ready", 32'(ev_ready), 32'd1);
    ev_valid = 1'b1; ev_duration = 16'd1; ev_gap = 16'd0;
    step();
    ev_valid = 1'b0;
    step();
    chk("t6_cmd_low", 32'(cmd), 32'd0);
    run_len(0, 1'b0, n);
    chk("t6_low", 32'(n), 32'd10);
    run_len(1, 1'b1, n);
    chk("t6_gap_busy_len", 32'(n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
